// File: rtl/lcd_write_arbiter.sv
// Two-requester arbiter for the character-LCD write path with cursor tracking and auto line wrap.
// Build option: define ROUND_ROBIN_EN for alternating grants; the default is fixed priority (req0 wins).
module lcd_write_arbiter #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int BUSY_TIMEOUT = 255,
  parameter int GAP_CYCLES   = 40
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_is_cmd,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_is_cmd,
  output logic       o_req1_ready,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_is_cmd,
  output logic       o_lcd_send,
  input  logic       i_lcd_busy,
  output logic [4:0] o_cur_col,
  output logic       o_cur_row,
  output logic       o_err_timeout,
  output logic       o_idle
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LP_COLS  = 5'(COLS);
  localparam logic [4:0]    LP_LAST  = 5'(COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP} state_t;

  state_t        r_state;
  logic [7:0]    r_hold_data;
  logic          r_hold_cmd;
  logic          r_pos;
  logic [7:0]    r_lcd_data;
  logic          r_lcd_is_cmd;
  logic          r_send;
  logic [4:0]    r_col;
  logic          r_row;
  logic          r_err;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;

  logic       w_gnt1, w_ok, w_hs, w_cmd, w_wrap, w_next_row;
  logic [7:0] w_data;
  logic [4:0] w_addr_col;

`ifdef ROUND_ROBIN_EN
  logic r_last_grant;
  assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_last_grant <= 1'b1;
    else if (w_hs) r_last_grant <= w_gnt1;
  end
`else
  assign w_gnt1 = i_req1_valid & ~i_req0_valid;
`endif

  assign w_ok         = (r_state == S_IDLE) & ~i_rst;
  assign o_req0_ready = w_ok & i_req0_valid & ~w_gnt1;
  assign o_req1_ready = w_ok & w_gnt1;
  assign w_hs         = o_req0_ready | o_req1_ready;
  assign w_data       = w_gnt1 ? i_req1_data : i_req0_data;
  assign w_cmd        = w_gnt1 ? i_req1_is_cmd : i_req0_is_cmd;
  assign w_wrap       = ~w_cmd & (r_col == LP_COLS);
  assign w_next_row   = (ROWS == 2) ? ~r_row : 1'b0;
  assign w_addr_col   = ({1'b0, r_hold_data[3:0]} > LP_LAST) ? LP_LAST : {1'b0, r_hold_data[3:0]};

  // r_pos marks that the in-flight byte is the auto-inserted line address;
  // the held character follows straight out of GAP without re-arbitration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hold_data  <= 8'h00;
      r_hold_cmd   <= 1'b0;
      r_pos        <= 1'b0;
      r_lcd_data   <= 8'h00;
      r_lcd_is_cmd <= 1'b0;
      r_send       <= 1'b0;
      r_col        <= 5'd0;
      r_row        <= 1'b0;
      r_err        <= 1'b0;
      r_tmo        <= '0;
      r_gap        <= '0;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_hold_data <= w_data;
          r_hold_cmd  <= w_cmd;
          r_pos       <= w_wrap;
          r_send      <= 1'b1;
          r_state     <= S_SEND;
          if (w_wrap) begin
            r_lcd_data   <= w_next_row ? 8'hC0 : 8'h80;
            r_lcd_is_cmd <= 1'b1;
          end else begin
            r_lcd_data   <= w_data;
            r_lcd_is_cmd <= w_cmd;
          end
        end
        S_SEND: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (i_lcd_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WAIT_LO: if (!i_lcd_busy) begin
          r_gap   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap != GAP_LAST) begin
            r_gap <= r_gap + 1'b1;
          end else if (r_pos) begin
            r_col        <= 5'd0;
            r_row        <= w_next_row;
            r_pos        <= 1'b0;
            r_lcd_data   <= r_hold_data;
            r_lcd_is_cmd <= 1'b0;
            r_send       <= 1'b1;
            r_state      <= S_SEND;
          end else begin
            r_state <= S_IDLE;
            if (!r_hold_cmd) begin
              if (r_col != LP_COLS) r_col <= r_col + 5'd1;
            end else if (r_hold_data inside {8'h01, 8'h02, 8'h03}) begin
              r_col <= 5'd0;
              r_row <= 1'b0;
            end else if (r_hold_data[7]) begin
              r_col <= w_addr_col;
              r_row <= r_hold_data[6];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lcd_data    = r_lcd_data;
  assign o_lcd_is_cmd  = r_lcd_is_cmd;
  assign o_lcd_send    = r_send;
  assign o_cur_col     = r_col;
  assign o_cur_row     = r_row;
  assign o_err_timeout = r_err;
  assign o_idle        = (r_state == S_IDLE);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed + randomized bench for lcd_write_arbiter; reference model tracks the cursor and expected byte stream.
module tb_lcd_write_arbiter;
  localparam int COLS = 16, ROWS = 2, BUSY_TIMEOUT = 255, GAP_CYCLES = 40, BUSY_LEN = 10;

  logic       clk = 1'b0, rst = 1'b1;
  logic       v0 = 1'b0, c0 = 1'b0, v1 = 1'b0, c1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, lcd_is_cmd, lcd_send, cur_row, err_timeout, idle;
  logic       lcd_busy = 1'b0;
  logic [7:0] lcd_data;
  logic [4:0] cur_col;

  lcd_write_arbiter #(.COLS(COLS), .ROWS(ROWS), .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_data(d0), .i_req0_is_cmd(c0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_data(d1), .i_req1_is_cmd(c1), .o_req1_ready(r1),
    .o_lcd_data(lcd_data), .o_lcd_is_cmd(lcd_is_cmd), .o_lcd_send(lcd_send), .i_lcd_busy(lcd_busy),
    .o_cur_col(cur_col), .o_cur_row(cur_row), .o_err_timeout(err_timeout), .o_idle(idle));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int got_q[$], exp_q[$], scyc_q[$];
  int busy_cnt = 0;
  bit busy_en = 1'b1;
  int m_col = 0, m_row = 0, m_err = 0;

  // LCD model: busy rises the cycle after a strobe and stays high BUSY_LEN cycles
  always @(negedge clk) begin
    if (busy_cnt > 0) begin lcd_busy = 1'b1; busy_cnt--; end
    else lcd_busy = 1'b0;
    if (lcd_send) begin
      got_q.push_back({23'd0, lcd_is_cmd, lcd_data});
      scyc_q.push_back(cyc);
      if (busy_en) busy_cnt = BUSY_LEN;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rchar();
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic model_byte(input bit cmd, input logic [7:0] d);
    int nr;
    if (!cmd && m_col == COLS) begin
      nr = (m_row + 1) % ROWS;
      exp_q.push_back(nr == 1 ? 32'h1C0 : 32'h180);
      m_col = 0;
      m_row = nr;
    end
    exp_q.push_back({23'd0, cmd, d});
    if (!cmd) m_col = (m_col < COLS) ? m_col + 1 : COLS;
    else if (d >= 8'h01 && d <= 8'h03) begin m_col = 0; m_row = 0; end
    else if (d[7]) begin
      m_col = (int'(d[3:0]) > COLS - 1) ? COLS - 1 : int'(d[3:0]);
      m_row = int'(d[6]);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_lcd_is_cmd", int'(lcd_is_cmd), 0);
    chk("rst_lcd_send", int'(lcd_send), 0);
    chk("rst_ready", int'({r1, r0}), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_idle", int'(idle), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_col = 0; m_row = 0; m_err = 0;
    got_q.delete(); exp_q.delete(); scyc_q.delete();
    chk_reset_state();
  endtask

  // Called at a negedge with requester inputs already driven.
  task automatic xfer(input int who_exp, input bit drop);
    int t, who, hs, nexp, g, e;
    t = 0;
    #1;
    while (!(r0 || r1) && t < 300) begin @(negedge clk); #1; t++; end
    chk("ready_seen", int'(r0 || r1), 1);
    who = r1 ? 1 : 0;
    chk("grant", who, who_exp);
    hs = cyc;
    model_byte(who ? c1 : c0, who ? d1 : d0);
    nexp = exp_q.size();
    @(posedge clk); #1;
    if (drop) begin v0 = 1'b0; v1 = 1'b0; end
    else if (who == 1) d1 = rchar();
    else d0 = rchar();
    t = 0;
    do begin @(negedge clk); t++; end while (!idle && t < 2000);
    chk("idle_reached", int'(idle), 1);
    chk("send_latency", scyc_q.size() > 0 ? scyc_q[0] : -1, hs + 1);
    if (nexp == 2 && busy_en)
      chk("wrap_char_latency", scyc_q.size() > 1 ? scyc_q[1] : -1, hs + 1 + BUSY_LEN + 1 + GAP_CYCLES + 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      chk("send_byte", g, e);
    end
    chk("extra_sends", got_q.size(), 0);
    got_q.delete(); scyc_q.delete();
    chk("cur_col", int'(cur_col), m_col);
    chk("cur_row", int'(cur_row), m_row);
    chk("err_timeout", int'(err_timeout), m_err);
  endtask

  task automatic req(input int who, input bit cmd, input logic [7:0] d);
    if (who == 1) begin v1 = 1'b1; c1 = cmd; d1 = d; end
    else begin v0 = 1'b1; c0 = cmd; d0 = d; end
    xfer(who, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and a single character from req0
    do_reset();
    req(0, 1'b0, 8'h35);

    // 33 random characters via req1: wraps to row 1 before the 17th, row 0 before the 33rd
    do_reset();
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      req(1, 1'b0, rchar());
      if (i == 17) begin
        chk("wrap17_row", int'(cur_row), 1);
        chk("wrap17_col", int'(cur_col), 1);
      end
    end
    chk("wrap33_row", int'(cur_row), 0);

    // contention: both valid every cycle
    do_reset();
    @(negedge clk);
    v0 = 1'b1; c0 = 1'b0; d0 = rchar();
    v1 = 1'b1; c1 = 1'b0; d1 = rchar();
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      xfer(k % 2, 1'b0);
`else
      xfer(0, 1'b0);
`endif
    end
    v0 = 1'b0;
    xfer(1, 1'b1);

    // busy never rises: timeout is sticky, later requests still served
    do_reset();
    busy_en = 1'b0;
    m_err = 1;
    @(negedge clk);
    req(0, 1'b0, rchar());
    busy_en = 1'b1;
    @(negedge clk);
    req(1, 1'b0, rchar());
    do_reset();

    // cursor-tracking commands
    req(0, 1'b1, 8'hC7);
    @(negedge clk); req(0, 1'b1, 8'h01);
    @(negedge clk); req(0, 1'b1, 8'hC5);
    @(negedge clk); req(1, 1'b1, 8'h0C);
    @(negedge clk); req(0, 1'b1, 8'h02);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req(k % 2, 1'b1, 8'h80 | 8'($urandom_range(0, 127)));
    end

    // reset in WAIT_LO of a wrap command drops the held character
    do_reset();
    req(0, 1'b1, 8'h8F);
    @(negedge clk); req(0, 1'b0, rchar());
    chk("pre_wrap_col", int'(cur_col), COLS);
    @(negedge clk);
    v0 = 1'b1; c0 = 1'b0; d0 = rchar();
    #1;
    chk("wrap_ready", int'(r0), 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_during_wait_lo", int'(lcd_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    chk("abort_sends", got_q.size(), 1);
    chk("abort_cmd_byte", got_q.size() > 0 ? got_q[0] : -1, 32'h1C0);
    repeat (150) @(negedge clk);
    chk("abort_no_more_sends", got_q.size(), 1);
    chk("abort_idle", int'(idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
